// File: rtl/b_io_l3_in_serialize_b_m_axi_fifo.sv
// Show-ahead valid/ready FIFO for the B_IO_L3_in_serialize_B m_axi read path.
// DEPTH-1 words live in a simple dual-port RAM with a registered read address.
// One more word sits in the RAM output register, which drives out_data directly.

module B_IO_L3_in_serialize_B_m_axi_mem #(
    parameter MEM_STYLE  = "auto",
    parameter DATA_WIDTH = 32,
    parameter ADDR_WIDTH = 6,
    parameter DEPTH      = 63
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] dout
);
    (* ram_style = MEM_STYLE *)
    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-2];
    logic [ADDR_WIDTH-1:0] r_raddr_reg;

    // Write port; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (clk_en && we) begin
            r_mem[waddr] <= din;
        end
    end

    // Read port: address is registered, data is read from the previously registered address.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_raddr_reg <= {ADDR_WIDTH{1'b0}};
            dout        <= {DATA_WIDTH{1'b0}};
        end else if (clk_en) begin
            r_raddr_reg <= raddr;
            if (re) begin
                dout <= r_mem[r_raddr_reg];
            end
        end
    end
endmodule

module b_io_l3_in_serialize_b_m_axi_fifo #(
    parameter MEM_STYLE  = "auto",
    parameter DATA_WIDTH = 32,
    parameter ADDR_WIDTH = 6,
    parameter DEPTH      = 63
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   num_data_valid
);
    // Pointers run 0..DEPTH-2; the RAM never holds more than DEPTH-1 words.
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 2);
    localparam logic [ADDR_WIDTH:0]   MEM_FULL = (ADDR_WIDTH + 1)'(DEPTH - 1);

    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [ADDR_WIDTH:0]   r_mem_used;
    logic                  r_out_valid;
    logic                  r_in_ready;
    logic [ADDR_WIDTH:0]   r_num_data_valid;

    logic                  w_push;
    logic                  w_pop_mem;
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic [ADDR_WIDTH:0]   w_mem_used_next;
    logic                  w_out_valid_next;
    logic [DATA_WIDTH-1:0] w_dout;

    function automatic logic [ADDR_WIDTH-1:0] inc_ptr(input logic [ADDR_WIDTH-1:0] x);
        return (x == LAST_PTR) ? {ADDR_WIDTH{1'b0}} : x + ADDR_WIDTH'(1);
    endfunction

    // Handshake decode and next-state occupancy / output-valid.
    always_comb begin
        w_push          = in_valid & r_in_ready;
        w_pop_mem       = (r_mem_used != {(ADDR_WIDTH + 1){1'b0}}) & (~r_out_valid | out_ready);
        // Presenting the next address on a pop keeps the RAM's registered address equal to rptr.
        w_raddr         = w_pop_mem ? inc_ptr(r_rptr) : r_rptr;
        w_mem_used_next = r_mem_used;
        case ({w_push, w_pop_mem})
            2'b10:   w_mem_used_next = r_mem_used + (ADDR_WIDTH + 1)'(1);
            2'b01:   w_mem_used_next = r_mem_used - (ADDR_WIDTH + 1)'(1);
            default: w_mem_used_next = r_mem_used;
        endcase
        if (w_pop_mem) begin
            w_out_valid_next = 1'b1;
        end else if (out_ready) begin
            w_out_valid_next = 1'b0;
        end else begin
            w_out_valid_next = r_out_valid;
        end
    end

    // Pointer, occupancy and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr           <= {ADDR_WIDTH{1'b0}};
            r_rptr           <= {ADDR_WIDTH{1'b0}};
            r_mem_used       <= {(ADDR_WIDTH + 1){1'b0}};
            r_out_valid      <= 1'b0;
            r_in_ready       <= 1'b1;
            r_num_data_valid <= {(ADDR_WIDTH + 1){1'b0}};
        end else begin
            if (w_push) begin
                r_wptr <= inc_ptr(r_wptr);
            end
            if (w_pop_mem) begin
                r_rptr <= inc_ptr(r_rptr);
            end
            r_mem_used       <= w_mem_used_next;
            r_out_valid      <= w_out_valid_next;
            // Registered from next state, so a full RAM blocks input even in a popping cycle.
            r_in_ready       <= (w_mem_used_next != MEM_FULL);
            r_num_data_valid <= w_mem_used_next + {{ADDR_WIDTH{1'b0}}, w_out_valid_next};
        end
    end

    B_IO_L3_in_serialize_B_m_axi_mem #(
        .MEM_STYLE  (MEM_STYLE),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk    (clk),
        .reset  (reset),
        .clk_en (1'b1),
        .we     (w_push),
        .waddr  (r_wptr),
        .din    (in_data),
        .re     (w_pop_mem),
        .raddr  (w_raddr),
        .dout   (w_dout)
    );

    assign in_ready       = r_in_ready;
    assign out_valid      = r_out_valid;
    assign out_data       = w_dout;
    assign num_data_valid = r_num_data_valid;
endmodule

// File: tb/tb_b_io_l3_in_serialize_b_m_axi_fifo.sv
// Self-checking bench: directed steps plus random backpressure against a queue model.

module tb_b_io_l3_in_serialize_b_m_axi_fifo;
    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int DEPTH = 63;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW:0]   num_data_valid;

    int            total;
    int            bad;
    logic [DW-1:0] q [$];
    logic          hold;
    logic [DW-1:0] hold_data;

    b_io_l3_in_serialize_b_m_axi_fifo #(
        .MEM_STYLE  ("auto"),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .num_data_valid (num_data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One clock of traffic: the model is simply the ordered list of words the FIFO holds.
    task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy, output logic acc);
        logic [DW-1:0] exp_w;
        logic          pop;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        if (hold) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", 64'(out_data), 64'(hold_data));
        end
        check("in_ready", 64'(in_ready), 64'((q.size() - int'(out_valid)) != DEPTH - 1));
        check("valid_without_data", 64'(out_valid && (q.size() == 0)), 64'd0);
        acc = iv & in_ready;
        pop = out_valid & ordy;
        if (pop && q.size() != 0) begin
            exp_w = q.pop_front();
            check("out_data", 64'(out_data), 64'(exp_w));
        end
        if (acc) q.push_back(d);
        hold      = out_valid & ~ordy;
        hold_data = out_data;
        cyc();
        check("num_data_valid", 64'(num_data_valid), 64'(q.size()));
    endtask

    initial begin
        logic acc;
        int   n_acc;
        int   sent;
        int   cycles;
        total = 0;
        bad   = 0;
        hold  = 1'b0;

        // Reset held two cycles with in_valid high: nothing may be written.
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hFFFF_FFFF;
        out_ready = 1'b0;
        cyc();
        cyc();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_ndv", 64'(num_data_valid), 64'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        cyc();
        cyc();
        check("post_rst_ndv", 64'(num_data_valid), 64'd0);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);

        // Single word: two-cycle latency, occupancy 0,1,1,0.
        check("single_ndv0", 64'(num_data_valid), 64'd0);
        drive(1'b1, 32'hA5A5_0001, 1'b1, acc);
        check("single_acc", 64'(acc), 64'd1);
        check("single_ov1", 64'(out_valid), 64'd0);
        check("single_ndv1", 64'(num_data_valid), 64'd1);
        drive(1'b0, 32'h0, 1'b1, acc);
        check("single_ov2", 64'(out_valid), 64'd1);
        check("single_data2", 64'(out_data), 64'hA5A5_0001);
        check("single_ndv2", 64'(num_data_valid), 64'd1);
        drive(1'b0, 32'h0, 1'b1, acc);
        check("single_ov3", 64'(out_valid), 64'd0);
        check("single_ndv3", 64'(num_data_valid), 64'd0);

        // Fill with no consumer: exactly DEPTH words accepted, the next held off.
        n_acc = 0;
        for (int i = 1; i <= DEPTH + 1; i++) begin
            drive(1'b1, 32'(i), 1'b0, acc);
            if (acc) n_acc++;
        end
        check("fill_accepted", 64'(n_acc), 64'(DEPTH));
        check("fill_in_ready", 64'(in_ready), 64'd0);
        check("fill_ndv", 64'(num_data_valid), 64'(DEPTH));
        check("fill_head", 64'(out_data), 64'd1);
        drive(1'b0, 32'h0, 1'b1, acc);
        check("fill_ready_back", 64'(in_ready), 64'd1);
        cycles = 0;
        while (q.size() != 0 && cycles < 200) begin
            drive(1'b0, 32'h0, 1'b1, acc);
            cycles++;
        end
        check("fill_drain", 64'(q.size()), 64'd0);
        drive(1'b0, 32'h0, 1'b1, acc);
        check("fill_empty_ov", 64'(out_valid), 64'd0);

        // Streaming across several pointer wraps at one word per cycle.
        for (int i = 0; i < 200; i++) begin
            if (i >= 2) check("stream_ov", 64'(out_valid), 64'd1);
            drive(1'b1, 32'(1000 + i), 1'b1, acc);
            if (!acc) check("stream_acc", 64'(acc), 64'd1);
        end
        cycles = 0;
        while (q.size() != 0 && cycles < 200) begin
            drive(1'b0, 32'h0, 1'b1, acc);
            cycles++;
        end
        check("stream_drain", 64'(q.size()), 64'd0);

        // Random valid/ready at roughly 50% each.
        sent   = 0;
        cycles = 0;
        while (sent < 10000 && cycles < 60000) begin
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), acc);
            if (acc) sent++;
            cycles++;
        end
        check("rand_sent", 64'(sent), 64'd10000);
        cycles = 0;
        while (q.size() != 0 && cycles < 500) begin
            drive(1'b0, 32'h0, 1'($urandom_range(0, 1)), acc);
            cycles++;
        end
        check("rand_drain", 64'(q.size()), 64'd0);

        // Reset in the middle of a stream discards everything held.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'h5000_0000 + 32'(i), 1'b0, acc);
        end
        check("mid_ndv20", 64'(num_data_valid), 64'd20);
        reset    = 1'b1;
        in_valid = 1'b0;
        cyc();
        reset = 1'b0;
        q.delete();
        hold = 1'b0;
        check("mid_rst_ov", 64'(out_valid), 64'd0);
        check("mid_rst_ndv", 64'(num_data_valid), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        drive(1'b1, 32'hDEAD_0020, 1'b1, acc);
        check("mid_ov1", 64'(out_valid), 64'd0);
        drive(1'b0, 32'h0, 1'b1, acc);
        check("mid_ov2", 64'(out_valid), 64'd1);
        check("mid_data2", 64'(out_data), 64'hDEAD_0020);
        drive(1'b0, 32'h0, 1'b1, acc);
        check("mid_ov3", 64'(out_valid), 64'd0);
        check("mid_ndv3", 64'(num_data_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
